lut_equiv_sweeper: RTL and testbench

- Sequential equivalence checker for two N_IN-input Boolean functions, each given as a truth-table LUT.
  - Example pair: a gate-level form and an expression form of the same function.
- On start, it steps an input counter through all 2^N_IN minterms and evaluates both LUTs through a 2-stage pipeline.
- It counts mismatches and records the first mismatching minterm.
- Replaces hand-written $monitor sweeps in per-exercise test modules with one reusable, synthesizable checker.

---
 rtl/lut_equiv_sweeper.sv | 199 +++++++++++++++++++
 tb/tb_lut_equiv_sweeper.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lut_equiv_sweeper.sv
// ============================================================================
// lut_equiv_sweeper
// ----------------------------------------------------------------------------
// Sequential equivalence checker for two N_IN-input Boolean functions, each
// given as a truth-table LUT (bit m holds f(m), MSB of m is the first input).
// On start, both LUTs are captured. Then an input counter walks every
// minterm through a two-stage pipeline: stage 1 looks up the LUTs, and
// stage 2 registers the trace and compares. Mismatches are counted, and the
// first mismatching minterm is recorded.
//
// Handshake: start is a level sampled on a rising edge. It is honoured only
// in IDLE or DONE, and ignored while busy. done stays high and the results
// hold until the next honoured start. done drops on the edge that accepts it.
//
// Optional feature (macro LUT_EQUIV_STOP_ON_FAIL_EN):
//   When defined, the sweep stops on the edge that records the first mismatch.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a sweep (IDLE/DONE only)
//   lut_a      in   truth table A, L = 2**N_IN bits
//   lut_b      in   truth table B, same encoding
//   busy       out  high in SWEEP and DRAIN
//   done       out  high while in DONE
//   equal      out  valid in DONE: no mismatch found
//   mism_cnt   out  number of mismatching minterms
//   first_idx  out  first mismatching minterm (0 if none)
//   first_vld  out  a mismatch has been recorded
//   cur_in     out  minterm currently in stage 2
//   out_a      out  stage-2 value of lut_a[cur_in]
//   out_b      out  stage-2 value of lut_b[cur_in]
//   dbg_state  out  FSM state (0 IDLE, 1 SWEEP, 2 DRAIN, 3 DONE)
// ============================================================================
module lut_equiv_sweeper #(
    parameter int N_IN  = 2,
    parameter int CNT_W = N_IN + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   lut_a,
    input  logic [(1<<N_IN)-1:0]   lut_b,
    output logic                   busy,
    output logic                   done,
    output logic                   equal,
    output logic [CNT_W-1:0]       mism_cnt,
    output logic [N_IN-1:0]        first_idx,
    output logic                   first_vld,
    output logic [N_IN-1:0]        cur_in,
    output logic                   out_a,
    output logic                   out_b,
    output logic [1:0]             dbg_state
);

    localparam int L = 1 << N_IN;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [N_IN-1:0]    idx_q;
    logic [L-1:0]       luta_q;
    logic [L-1:0]       lutb_q;

    // Stage 1 pipeline registers
    logic               v1_q;
    logic [N_IN-1:0]    i1_q;
    logic               a1_q;
    logic               b1_q;

    // Registered outputs
    logic               busy_q;
    logic               done_q;
    logic               equal_q;
    logic [CNT_W-1:0]   mism_cnt_q;
    logic [N_IN-1:0]    first_idx_q;
    logic               first_vld_q;
    logic [N_IN-1:0]    cur_in_q;
    logic               out_a_q;
    logic               out_b_q;

    // Stage-2 comparison results for the current edge
    logic               mism_hit;
    logic               first_hit;
    logic               stop_d;
    logic [CNT_W-1:0]   mism_cnt_d;

    always_comb begin
        mism_hit   = v1_q && (a1_q != b1_q);
        first_hit  = mism_hit && !first_vld_q;
        mism_cnt_d = mism_cnt_q + CNT_W'(mism_hit);
`ifdef LUT_EQUIV_STOP_ON_FAIL_EN
        stop_d     = first_hit;
`else
        stop_d     = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            luta_q      <= '0;
            lutb_q      <= '0;
            v1_q        <= 1'b0;
            i1_q        <= '0;
            a1_q        <= 1'b0;
            b1_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            equal_q     <= 1'b0;
            mism_cnt_q  <= '0;
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
            cur_in_q    <= '0;
            out_a_q     <= 1'b0;
            out_b_q     <= 1'b0;
        end else begin
            // Stage 2. v1 is only set in SWEEP/DRAIN, so this never collides
            // with the result clearing done on an accepted start.
            if (v1_q) begin
                cur_in_q   <= i1_q;
                out_a_q    <= a1_q;
                out_b_q    <= b1_q;
                mism_cnt_q <= mism_cnt_d;
                if (first_hit) begin
                    first_idx_q <= i1_q;
                    first_vld_q <= 1'b1;
                end
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        luta_q      <= lut_a;
                        lutb_q      <= lut_b;
                        idx_q       <= '0;
                        mism_cnt_q  <= '0;
                        first_idx_q <= '0;
                        first_vld_q <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        equal_q     <= 1'b0;
                        state_q     <= S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    v1_q  <= 1'b1;
                    i1_q  <= idx_q;
                    a1_q  <= luta_q[idx_q];
                    b1_q  <= lutb_q[idx_q];
                    // Wraps to 0 after the last minterm; unused afterwards
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == N_IN'(L - 1)) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The last minterm is compared on this edge, so equal
                    // uses the updated count.
                    v1_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    equal_q <= (mism_cnt_d == '0);
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Early termination takes priority over normal sequencing
            if (stop_d) begin
                v1_q    <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                equal_q <= 1'b0;
                state_q <= S_DONE;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign equal     = equal_q;
    assign mism_cnt  = mism_cnt_q;
    assign first_idx = first_idx_q;
    assign first_vld = first_vld_q;
    assign cur_in    = cur_in_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lut_equiv_sweeper.sv
// ============================================================================
// tb_lut_equiv_sweeper
// ----------------------------------------------------------------------------
// Bench for lut_equiv_sweeper. It drives two instances (N_IN=2 and N_IN=3)
// that share the clock and reset. A select line routes stimulus and observed
// outputs to one instance at a time. The expected results come from a
// reference model built from the LUT bits: the XOR population count, the
// lowest differing minterm, and the trace order.
// ============================================================================
module tb_lut_equiv_sweeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] lut_a = '0;
    logic [7:0] lut_b = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // N_IN = 2 instance
    logic       busy2, done2, equal2, fv2, oa2, ob2;
    logic [2:0] mism2;
    logic [1:0] fidx2, cur2, st2;
    // N_IN = 3 instance
    logic       busy3, done3, equal3, fv3, oa3, ob3;
    logic [3:0] mism3;
    logic [2:0] fidx3, cur3;
    logic [1:0] st3;

    lut_equiv_sweeper #(.N_IN(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start && !sel),
        .lut_a(lut_a[3:0]), .lut_b(lut_b[3:0]),
        .busy(busy2), .done(done2), .equal(equal2), .mism_cnt(mism2),
        .first_idx(fidx2), .first_vld(fv2), .cur_in(cur2),
        .out_a(oa2), .out_b(ob2), .dbg_state(st2)
    );

    lut_equiv_sweeper #(.N_IN(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start && sel),
        .lut_a(lut_a), .lut_b(lut_b),
        .busy(busy3), .done(done3), .equal(equal3), .mism_cnt(mism3),
        .first_idx(fidx3), .first_vld(fv3), .cur_in(cur3),
        .out_a(oa3), .out_b(ob3), .dbg_state(st3)
    );

    // Outputs of the selected instance
    logic       o_busy, o_done, o_equal, o_fv, o_oa, o_ob;
    logic [7:0] o_mism, o_fidx, o_cur;
    logic [1:0] o_st;
    assign o_busy  = sel ? busy3  : busy2;
    assign o_done  = sel ? done3  : done2;
    assign o_equal = sel ? equal3 : equal2;
    assign o_fv    = sel ? fv3    : fv2;
    assign o_oa    = sel ? oa3    : oa2;
    assign o_ob    = sel ? ob3    : ob2;
    assign o_mism  = sel ? 8'(mism3) : 8'(mism2);
    assign o_fidx  = sel ? 8'(fidx3) : 8'(fidx2);
    assign o_cur   = sel ? 8'(cur3)  : 8'(cur2);
    assign o_st    = sel ? st3 : st2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", tag, obs, exp, $time, sel);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  32'(o_busy),  32'd0);
        check({tag, "_done"},  32'(o_done),  32'd0);
        check({tag, "_equal"}, 32'(o_equal), 32'd0);
        check({tag, "_mism"},  32'(o_mism),  32'd0);
        check({tag, "_fidx"},  32'(o_fidx),  32'd0);
        check({tag, "_fv"},    32'(o_fv),    32'd0);
        check({tag, "_cur"},   32'(o_cur),   32'd0);
        check({tag, "_oa"},    32'(o_oa),    32'd0);
        check({tag, "_ob"},    32'(o_ob),    32'd0);
        check({tag, "_state"}, 32'(o_st),    32'd0);
    endtask

    // mode: 0 plain, 1 toggle LUT inputs mid-sweep, 2 start pulse at edge 3,
    //       3 asynchronous reset after edge 2
    task automatic run_sweep(input int n, input logic [7:0] la, input logic [7:0] lb, input int mode);
        int   len;
        int   exp_cnt;
        int   exp_first;
        logic exp_fv;
        len       = 1 << n;
        exp_cnt   = 0;
        exp_first = 0;
        exp_fv    = 1'b0;
        for (int m = 0; m < len; m++) begin
            if (la[m] != lb[m]) begin
                exp_cnt++;
                if (!exp_fv) begin
                    exp_first = m;
                    exp_fv    = 1'b1;
                end
            end
        end

        @(negedge clk);
        sel   = (n == 3);
        lut_a = la;
        lut_b = lb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("e0_busy", 32'(o_busy), 32'd1);
        check("e0_done", 32'(o_done), 32'd0);
        check("e0_mism", 32'(o_mism), 32'd0);
        check("e0_fv",   32'(o_fv),   32'd0);

        for (int k = 1; k <= len + 1; k++) begin
            if (mode == 1 && k == 2) begin
                lut_a = ~la;
                lut_b = ~lb;
            end
            if (mode == 2 && k == 3) start = 1'b1;
            if (mode == 2 && k == 4) start = 1'b0;
            @(negedge clk);
            if (mode == 3 && k == 2) begin
                rst_n = 1'b0;
                #1;
                check_zero("rst_mid");
                @(negedge clk);
                check_zero("rst_hold");
                rst_n = 1'b1;
                return;
            end
            if (k >= 2) begin
                check("trace_cur", 32'(o_cur), 32'(k - 2));
                check("trace_a",   32'(o_oa),  32'(la[k-2]));
                check("trace_b",   32'(o_ob),  32'(lb[k-2]));
            end
            check("sweep_busy", 32'(o_busy), 32'(k <= len));
            check("sweep_done", 32'(o_done), 32'(k == len + 1));
        end
        start = 1'b0;

        check("res_equal", 32'(o_equal), 32'(exp_cnt == 0));
        check("res_mism",  32'(o_mism),  32'(exp_cnt));
        check("res_fidx",  32'(o_fidx),  32'(exp_first));
        check("res_fv",    32'(o_fv),    32'(exp_fv));
        @(negedge clk);
        check("hold_done", 32'(o_done), 32'd1);
        check("hold_mism", 32'(o_mism), 32'(exp_cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        #12;
        sel = 1'b0;
        check_zero("reset2");
        sel = 1'b1;
        check_zero("reset3");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_sweep(2, 8'h02, 8'h02, 0);
        run_sweep(2, 8'h02, 8'h0D, 0);
        run_sweep(2, 8'h02, 8'h02, 0);   // restart from DONE with mism_cnt=4
        run_sweep(2, 8'h02, 8'h0A, 1);
        run_sweep(3, 8'hE8, 8'hE9, 2);
        run_sweep(3, 8'hE8, 8'hE9, 3);
        run_sweep(3, 8'hE8, 8'hE8, 0);
        run_sweep(2, 8'h0F, 8'h00, 0);   // every minterm differs

        // Randomized cases
        for (int r = 0; r < 24; r++) begin
            int         n;
            logic [7:0] la;
            logic [7:0] lb;
            n  = int'($urandom_range(2, 3));
            la = 8'($urandom);
            lb = ($urandom_range(0, 3) == 0) ? la : (la ^ 8'($urandom));
            run_sweep(n, la, lb, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
